layer_sequencer: RTL

- Per-sample scheduler for the conv pipeline. On each rising edge of sample_clk it clocks the input shift buffer once, then starts each conv stage in order, waiting on that stage's out_v before moving on.
- After selected stages it strobes the downstream activation cache, and after the last stage it pulses an output-latch strobe.
- It replaces the hand-written per-layer state chain inside the network module and adds timeout and overrun detection.

---
 rtl/layer_sequencer.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/layer_sequencer.sv
// Per-sample scheduler: shifts the input buffer, then starts each conv stage in turn.
// Define LAYER_SEQ_STATS_EN to build the frame-length and overrun statistics counters.
module layer_sequencer #(
  parameter int unsigned             N_STAGES   = 8,
  parameter logic [N_STAGES-1:0]     CACHE_MASK = 8'b0000_0101,
  parameter int unsigned             TIMEOUT    = 4095,
  parameter int unsigned             CNT_W      = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_clk,
  input  logic [N_STAGES-1:0] stage_done,
  output logic                lsb_clk,
  output logic [N_STAGES-1:0] stage_start,
  output logic [N_STAGES-1:0] cache_clk,
  output logic                out_latch,
  output logic                busy,
  output logic                timeout_err,
  output logic [CNT_W-1:0]    last_busy_cycles,
  output logic [CNT_W-1:0]    overrun_count
);

  localparam int unsigned IW = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
  localparam int unsigned WW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_STAGES - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LSB    = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_CACHE  = 3'd4;
  localparam logic [2:0] S_OUTPUT = 3'd5;

  logic [2:0]          state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [WW-1:0]       wait_q, wait_d;
  logic                prev_q, seen_low_q;
  logic                lsb_q, lsb_d;
  logic [N_STAGES-1:0] start_q, start_d;
  logic [N_STAGES-1:0] cache_q, cache_d;
  logic                out_q, out_d;
  logic                busy_q;
  logic                terr_q, terr_d;
  logic                sample_edge;

  // seen_low_q blocks a false edge when sample_clk is already high as reset releases.
  assign sample_edge = sample_clk & ~prev_q & seen_low_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wait_d  = wait_q;
    lsb_d   = 1'b0;
    start_d = '0;
    cache_d = '0;
    out_d   = 1'b0;
    terr_d  = terr_q;
    if (sample_edge) begin
      state_d = S_LSB;
    end else begin
      case (state_q)
        S_LSB: begin
          lsb_d   = 1'b1;
          idx_d   = '0;
          state_d = S_START;
        end
        S_START: begin
          start_d[idx_q] = 1'b1;
          wait_d         = '0;
          state_d        = S_WAIT;
        end
        S_WAIT: begin
          wait_d = wait_q + WW'(1);
          if (stage_done[idx_q]) begin
            if (CACHE_MASK[idx_q]) begin
              state_d = S_CACHE;
            end else if (idx_q == LAST_IDX) begin
              state_d = S_OUTPUT;
            end else begin
              idx_d   = idx_q + IW'(1);
              state_d = S_START;
            end
          end else if (wait_d == WW'(TIMEOUT)) begin
            terr_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_CACHE: begin
          cache_d[idx_q] = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = S_OUTPUT;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = S_START;
          end
        end
        S_OUTPUT: begin
          out_d   = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      wait_q     <= '0;
      prev_q     <= 1'b0;
      seen_low_q <= ~sample_clk;
      lsb_q      <= 1'b0;
      start_q    <= '0;
      cache_q    <= '0;
      out_q      <= 1'b0;
      busy_q     <= 1'b0;
      terr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      wait_q     <= wait_d;
      prev_q     <= sample_clk;
      seen_low_q <= seen_low_q | ~sample_clk;
      lsb_q      <= lsb_d;
      start_q    <= start_d;
      cache_q    <= cache_d;
      out_q      <= out_d;
      busy_q     <= (state_d != S_IDLE);
      terr_q     <= terr_d;
    end
  end

  assign lsb_clk     = lsb_q;
  assign stage_start = start_q;
  assign cache_clk   = cache_q;
  assign out_latch   = out_q;
  assign busy        = busy_q;
  assign timeout_err = terr_q;

`ifdef LAYER_SEQ_STATS_EN
  logic [CNT_W-1:0] frame_cnt_q, lbc_q, ovr_q;

  // The latched length includes the OUTPUT cycle itself, hence the +1.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
      lbc_q       <= '0;
      ovr_q       <= '0;
    end else begin
      if (state_q == S_LSB) begin
        frame_cnt_q <= CNT_W'(1);
      end else if (state_q != S_IDLE && frame_cnt_q != '1) begin
        frame_cnt_q <= frame_cnt_q + CNT_W'(1);
      end
      if (state_q == S_OUTPUT && !sample_edge) begin
        lbc_q <= (frame_cnt_q == '1) ? '1 : frame_cnt_q + CNT_W'(1);
      end
      if (sample_edge && state_q != S_IDLE && ovr_q != '1) begin
        ovr_q <= ovr_q + CNT_W'(1);
      end
    end
  end

  assign last_busy_cycles = lbc_q;
  assign overrun_count    = ovr_q;
`else
  assign last_busy_cycles = '0;
  assign overrun_count    = '0;
`endif

endmodule
